ccip_txn_tracker: RTL and testbench
===================================

Name: ccip_txn_tracker

Overview:
Parametrised CCI-P transaction tracker and error checker. It matches every AFU request tag against its response on up to NUM_CH request/response channel pairs, keeps per-channel outstanding, high-water, latency and error statistics, and emits one error event per cycle for the ASE logger to print. It is instantiated beside the transaction logger in the ASE hardware top and is passive: it never drives CCI-P.

Parameters:
NUM_CH, 2, number of request/response channel pairs (ch0 = C0 read, ch1 = C1 write); range 1..4.
TAG_WIDTH, 6, low mdata bits used as the tag; gives 2^TAG_WIDTH table entries per channel.
TS_WIDTH, 32, width of the free-running cycle timestamp and of latency values.
TIMEOUT_CYCLES, 4096, age above which an outstanding entry is reported as timed out; must be less than 2^TS_WIDTH.
CNT_WIDTH, 16, width of the response, drop and outstanding counters.

Ports:
clk  in  1  CCI-P clock.
SoftReset  in  1  asynchronous, active-high reset.
stats_clear  in  1  synchronous clear of statistics only.
req_valid  in  NUM_CH  request strobe per channel.
req_tag  in  NUM_CH*TAG_WIDTH  request tag; channel c occupies bits [c*TAG_WIDTH +: TAG_WIDTH].
rsp_valid  in  NUM_CH  response strobe per channel.
rsp_tag  in  NUM_CH*TAG_WIDTH  response tag, packed the same way as req_tag.
outstanding  out  NUM_CH*CNT_WIDTH  live outstanding count per channel.
hwm  out  NUM_CH*CNT_WIDTH  outstanding high-water mark per channel.
rsp_count  out  NUM_CH*CNT_WIDTH  retired responses per channel (saturating).
lat_max  out  NUM_CH*TS_WIDTH  maximum observed latency per channel.
err_sticky  out  NUM_CH*3  sticky flags per channel: {timeout, dup, orphan}.
err_valid  out  1  one-cycle error event pulse.
err_code  out  2  error code: 1 = orphan, 2 = dup, 3 = timeout.
err_ch  out  2  channel of the reported event.
err_tag  out  TAG_WIDTH  tag of the reported event.
err_drop_cnt  out  CNT_WIDTH  count of events lost to arbitration (saturating).

Behaviour:
- Reset: all outputs 0, all table valid/timed_out bits 0, timestamp 0, scan pointers 0.
- Timestamp: `now` increments every cycle and wraps mod 2^TS_WIDTH. Age and latency are computed as (now - ts[tag]) mod 2^TS_WIDTH.
- Table per channel: 2^TAG_WIDTH entries, each {valid, timed_out, ts}.
- Response, processed first within a cycle:
  - If entry valid: clear valid and timed_out; latency = now - ts; update lat_max; rsp_count++.
  - Else: orphan error; table unchanged.
- Request, processed after the response:
  - If entry valid (and not freed by a same-cycle response with the same tag): dup error; the entry is overwritten with ts = now, timed_out = 0, and outstanding is unchanged.
  - Else: set valid, ts = now, timed_out = 0; outstanding++.
- Same cycle, same tag, entry valid: retire then re-allocate, legal; outstanding net 0, latency recorded.
- Same cycle, same tag, entry idle: orphan for the response, then allocate for the request.
- hwm = max(hwm, outstanding) on the registered value. Counters saturate at all-ones.
- Timeout scanner:
  - One pointer per channel, advancing by 1 each cycle with wrap at 2^TAG_WIDTH-1 to 0.
  - If the entry is valid, not timed_out, and age > TIMEOUT_CYCLES: set timed_out and raise a timeout error.
  - If a request or response touches the scanned index in that cycle, skip the check that cycle.
  - A timed-out entry still retires normally on its response.
- Error events:
  - Candidates are collected in cycle t; err_valid is asserted in cycle t+1.
  - Priority: orphan > dup > timeout, then lowest channel.
  - Every losing candidate increments err_drop_cnt by 1 each.
  - err_sticky bits are set for all candidates regardless of arbitration.
- stats_clear: zeroes hwm, rsp_count, lat_max, err_sticky and err_drop_cnt. It does not touch tables or outstanding. If a clear coincides with an update, the clear wins for that cycle.
- Reset mid-operation: all state is lost immediately; responses arriving after reset are orphans.

Decomposition:
- Shared package ase_pkg gets the typedef of the table entry struct {valid, timed_out, ts} and an enum for err_code (ERR_NONE, ERR_ORPHAN, ERR_DUP, ERR_TIMEOUT).
- Sub-module ccip_txn_tracker_ch holds one channel's table, scanner, counters and its candidate flags. It is instantiated NUM_CH times via generate.
- The top level contains the timestamp counter, the error arbiter and output packing.

Test Plan:
1. ch0: request tag 5 at t=10, response tag 5 at t=30 → lat_max[0]=20, rsp_count[0]=1, outstanding[0]=0, no err_valid.
2. Response on ch1 tag 9 with no request → err_valid at the next cycle with err_code=1, err_ch=1, err_tag=9; err_sticky[1] orphan bit set.
3. Two requests on ch0 tag 3 at t=5 and t=8, response at t=12 → dup event at t=9; lat_max[0]=4; outstanding[0]=0.
4. TIMEOUT_CYCLES=16, TAG_WIDTH=2, request ch0 tag 1 with no response → exactly one timeout event within 16+4 cycles after the age exceeds 16; a late response then retires with no orphan.
5. Same cycle: orphan on ch0, dup on ch1, timeout on ch1 → err_code=1, err_ch=0 reported; err_drop_cnt=2; all three sticky bits set.
6. Fill all 64 tags on ch0, then assert stats_clear → hwm[0]=0 and outstanding[0]=64; next request cycle raises hwm[0] to 64. Assert SoftReset mid-burst → all outputs 0.

Source files
------------

// File: rtl/ase_pkg.sv
// ase_pkg: shared types for the ASE CCI-P transaction tracker.
// Table entries hold timestamps of up to ENTRY_TS_W bits.
package ase_pkg;

    localparam int ENTRY_TS_W = 32;

    typedef struct packed {
        logic                  valid;
        logic                  timed_out;
        logic [ENTRY_TS_W-1:0] ts;
    } entry_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ORPHAN  = 2'd1,
        ERR_DUP     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

endpackage

// File: rtl/ccip_txn_tracker_ch.sv
// ccip_txn_tracker_ch: one channel's tag table, timeout scanner, statistics and error candidates.
module ccip_txn_tracker_ch
    import ase_pkg::*;
#(
    parameter int TAG_WIDTH      = 6,
    parameter int TS_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stats_clear,
    input  logic [TS_WIDTH-1:0]  now,
    input  logic                 req_valid,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 rsp_valid,
    input  logic [TAG_WIDTH-1:0] rsp_tag,
    output logic [CNT_WIDTH-1:0] outstanding,
    output logic [CNT_WIDTH-1:0] hwm,
    output logic [CNT_WIDTH-1:0] rsp_count,
    output logic [TS_WIDTH-1:0]  lat_max,
    output logic [2:0]           err_sticky,
    output logic                 orphan,
    output logic                 dup,
    output logic                 timeout,
    output logic [TAG_WIDTH-1:0] scan_tag
);

    localparam int DEPTH = 1 << TAG_WIDTH;

    entry_t              tbl [DEPTH];
    entry_t              rsp_e;
    entry_t              req_e;
    entry_t              scan_e;
    logic                rsp_hit;
    logic [TS_WIDTH-1:0] lat;
    logic [TS_WIDTH-1:0] age;

    always_comb begin
        rsp_e   = tbl[rsp_tag];
        req_e   = tbl[req_tag];
        scan_e  = tbl[scan_tag];
        rsp_hit = rsp_valid && rsp_e.valid;
        orphan  = rsp_valid && !rsp_e.valid;
        // a response retiring the same tag frees the slot for this cycle's request
        dup     = req_valid && req_e.valid && !(rsp_hit && rsp_tag == req_tag);
        lat     = now - rsp_e.ts[TS_WIDTH-1:0];
        age     = now - scan_e.ts[TS_WIDTH-1:0];
        timeout = scan_e.valid && !scan_e.timed_out && age > TS_WIDTH'(TIMEOUT_CYCLES)
                  && !(req_valid && req_tag == scan_tag) && !(rsp_valid && rsp_tag == scan_tag);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else begin
            if (rsp_hit) begin
                tbl[rsp_tag].valid     <= 1'b0;
                tbl[rsp_tag].timed_out <= 1'b0;
            end
            if (timeout) tbl[scan_tag].timed_out <= 1'b1;
            if (req_valid) tbl[req_tag] <= '{valid: 1'b1, timed_out: 1'b0, ts: ENTRY_TS_W'(now)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_tag    <= '0;
            outstanding <= '0;
            hwm         <= '0;
            rsp_count   <= '0;
            lat_max     <= '0;
            err_sticky  <= '0;
        end else begin
            scan_tag    <= scan_tag + 1'b1;
            outstanding <= outstanding + CNT_WIDTH'(req_valid && !dup) - CNT_WIDTH'(rsp_hit);
            hwm         <= stats_clear ? '0 : (outstanding > hwm ? outstanding : hwm);
            rsp_count   <= stats_clear ? '0 : rsp_count + CNT_WIDTH'(rsp_hit && !(&rsp_count));
            lat_max     <= stats_clear ? '0 : (rsp_hit && lat > lat_max ? lat : lat_max);
            err_sticky  <= stats_clear ? '0 : err_sticky | {timeout, dup, orphan};
        end
    end

endmodule

// File: rtl/ccip_txn_tracker.sv
// ccip_txn_tracker: passive CCI-P request/response tag tracker with per-channel statistics
// and a single arbitrated error event stream for the ASE logger.
module ccip_txn_tracker
    import ase_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int TAG_WIDTH      = 6,
    parameter int TS_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          SoftReset,
    input  logic                          stats_clear,
    input  logic [NUM_CH-1:0]             req_valid,
    input  logic [NUM_CH*TAG_WIDTH-1:0]   req_tag,
    input  logic [NUM_CH-1:0]             rsp_valid,
    input  logic [NUM_CH*TAG_WIDTH-1:0]   rsp_tag,
    output logic [NUM_CH*CNT_WIDTH-1:0]   outstanding,
    output logic [NUM_CH*CNT_WIDTH-1:0]   hwm,
    output logic [NUM_CH*CNT_WIDTH-1:0]   rsp_count,
    output logic [NUM_CH*TS_WIDTH-1:0]    lat_max,
    output logic [NUM_CH*3-1:0]           err_sticky,
    output logic                          err_valid,
    output logic [1:0]                    err_code,
    output logic [1:0]                    err_ch,
    output logic [TAG_WIDTH-1:0]          err_tag,
    output logic [CNT_WIDTH-1:0]          err_drop_cnt
);

    localparam int DW = CNT_WIDTH + 1;

    logic [TS_WIDTH-1:0]         now;
    logic [NUM_CH-1:0]           orphan;
    logic [NUM_CH-1:0]           dup;
    logic [NUM_CH-1:0]           timeout;
    logic [NUM_CH*TAG_WIDTH-1:0] scan_tag;
    err_code_t                   sel_code;
    logic [1:0]                  sel_ch;
    logic [TAG_WIDTH-1:0]        sel_tag;
    logic [3:0]                  n_cand;
    logic [DW-1:0]               drop_sum;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ccip_txn_tracker_ch #(
            .TAG_WIDTH      (TAG_WIDTH),
            .TS_WIDTH       (TS_WIDTH),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_ch (
            .clk         (clk),
            .rst         (SoftReset),
            .stats_clear (stats_clear),
            .now         (now),
            .req_valid   (req_valid[g]),
            .req_tag     (req_tag[g*TAG_WIDTH +: TAG_WIDTH]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_tag     (rsp_tag[g*TAG_WIDTH +: TAG_WIDTH]),
            .outstanding (outstanding[g*CNT_WIDTH +: CNT_WIDTH]),
            .hwm         (hwm[g*CNT_WIDTH +: CNT_WIDTH]),
            .rsp_count   (rsp_count[g*CNT_WIDTH +: CNT_WIDTH]),
            .lat_max     (lat_max[g*TS_WIDTH +: TS_WIDTH]),
            .err_sticky  (err_sticky[g*3 +: 3]),
            .orphan      (orphan[g]),
            .dup         (dup[g]),
            .timeout     (timeout[g]),
            .scan_tag    (scan_tag[g*TAG_WIDTH +: TAG_WIDTH])
        );
    end

    // later loops override earlier ones, so orphan beats dup beats timeout, lowest channel first
    always_comb begin
        sel_code = ERR_NONE;
        sel_ch   = '0;
        sel_tag  = '0;
        n_cand   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (timeout[i]) begin
                sel_code = ERR_TIMEOUT;
                sel_ch   = 2'(i);
                sel_tag  = scan_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (dup[i]) begin
                sel_code = ERR_DUP;
                sel_ch   = 2'(i);
                sel_tag  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (orphan[i]) begin
                sel_code = ERR_ORPHAN;
                sel_ch   = 2'(i);
                sel_tag  = rsp_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
        for (int i = 0; i < NUM_CH; i++) n_cand = n_cand + 4'(orphan[i]) + 4'(dup[i]) + 4'(timeout[i]);
        drop_sum = {1'b0, err_drop_cnt} + DW'(n_cand - 4'(|n_cand));
    end

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            now          <= '0;
            err_valid    <= 1'b0;
            err_code     <= '0;
            err_ch       <= '0;
            err_tag      <= '0;
            err_drop_cnt <= '0;
        end else begin
            now          <= now + 1'b1;
            err_valid    <= sel_code != ERR_NONE;
            err_code     <= sel_code;
            err_ch       <= sel_ch;
            err_tag      <= sel_tag;
            err_drop_cnt <= stats_clear ? '0 : (drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0]);
        end
    end

endmodule

// File: tb/tb_ccip_txn_tracker.sv
// tb_ccip_txn_tracker: directed tests on a default tracker and a small-table short-timeout tracker.
module tb_ccip_txn_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        b_rst, b_clr;
    logic [1:0]  b_req_valid, b_rsp_valid;
    logic [11:0] b_req_tag, b_rsp_tag;
    logic [31:0] b_outstanding, b_hwm, b_rsp_count;
    logic [63:0] b_lat_max;
    logic [5:0]  b_err_sticky;
    logic        b_err_valid;
    logic [1:0]  b_err_code, b_err_ch;
    logic [5:0]  b_err_tag;
    logic [15:0] b_err_drop_cnt;

    logic        s_rst, s_clr;
    logic [1:0]  s_req_valid, s_rsp_valid;
    logic [3:0]  s_req_tag, s_rsp_tag;
    logic [31:0] s_outstanding, s_hwm, s_rsp_count;
    logic [63:0] s_lat_max;
    logic [5:0]  s_err_sticky;
    logic        s_err_valid;
    logic [1:0]  s_err_code, s_err_ch;
    logic [1:0]  s_err_tag;
    logic [15:0] s_err_drop_cnt;

    int total = 0;
    int bad = 0;
    int t = 0;
    int b_nerr = 0;
    int s_nerr = 0;
    int s_last_t = 0;
    logic [1:0] s_last_code, s_last_ch, s_last_tag;

    ccip_txn_tracker dut (
        .clk(clk), .SoftReset(b_rst), .stats_clear(b_clr),
        .req_valid(b_req_valid), .req_tag(b_req_tag), .rsp_valid(b_rsp_valid), .rsp_tag(b_rsp_tag),
        .outstanding(b_outstanding), .hwm(b_hwm), .rsp_count(b_rsp_count), .lat_max(b_lat_max),
        .err_sticky(b_err_sticky), .err_valid(b_err_valid), .err_code(b_err_code), .err_ch(b_err_ch),
        .err_tag(b_err_tag), .err_drop_cnt(b_err_drop_cnt)
    );

    ccip_txn_tracker #(.TAG_WIDTH(2), .TIMEOUT_CYCLES(16)) dut_s (
        .clk(clk), .SoftReset(s_rst), .stats_clear(s_clr),
        .req_valid(s_req_valid), .req_tag(s_req_tag), .rsp_valid(s_rsp_valid), .rsp_tag(s_rsp_tag),
        .outstanding(s_outstanding), .hwm(s_hwm), .rsp_count(s_rsp_count), .lat_max(s_lat_max),
        .err_sticky(s_err_sticky), .err_valid(s_err_valid), .err_code(s_err_code), .err_ch(s_err_ch),
        .err_tag(s_err_tag), .err_drop_cnt(s_err_drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
        t++;
        if (b_err_valid) b_nerr++;
        if (s_err_valid) begin
            s_nerr++;
            s_last_t = t;
            s_last_code = s_err_code;
            s_last_ch = s_err_ch;
            s_last_tag = s_err_tag;
        end
    endtask

    task automatic goto(input int n);
        while (t < n) step();
    endtask

    task automatic idle_inputs();
        b_req_valid = '0; b_rsp_valid = '0; b_req_tag = '0; b_rsp_tag = '0; b_clr = 1'b0;
        s_req_valid = '0; s_rsp_valid = '0; s_req_tag = '0; s_rsp_tag = '0; s_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        b_rst = 1'b1;
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        s_rst = 1'b0;
        t = 0; b_nerr = 0; s_nerr = 0; s_last_t = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        b_rst = 1'b1;
        s_rst = 1'b1;
        #12;
        total++;
        if ({b_outstanding, b_hwm, b_rsp_count, b_lat_max, b_err_sticky, b_err_valid, b_err_code,
             b_err_ch, b_err_tag, b_err_drop_cnt} !== '0) begin
            bad++; $display("FAIL reset_big: outputs not all zero, outstanding=%h err_valid=%b", b_outstanding, b_err_valid);
        end
        total++;
        if ({s_outstanding, s_hwm, s_rsp_count, s_lat_max, s_err_sticky, s_err_valid, s_err_code,
             s_err_ch, s_err_tag, s_err_drop_cnt} !== '0) begin
            bad++; $display("FAIL reset_small: outputs not all zero, outstanding=%h err_valid=%b", s_outstanding, s_err_valid);
        end
    endtask

    task automatic test_latency();
        do_reset();
        goto(10);
        b_req_valid[0] = 1'b1; b_req_tag[5:0] = 6'd5;
        step();
        b_req_valid = '0;
        total++;
        if (b_outstanding[15:0] !== 16'd1) begin bad++; $display("FAIL lat_outstanding_open: got %0d want 1", b_outstanding[15:0]); end
        goto(30);
        b_rsp_valid[0] = 1'b1; b_rsp_tag[5:0] = 6'd5;
        step();
        b_rsp_valid = '0;
        step();
        total++;
        if (b_lat_max[31:0] !== 32'd20) begin bad++; $display("FAIL lat_max: got %0d want 20", b_lat_max[31:0]); end
        total++;
        if (b_rsp_count[15:0] !== 16'd1) begin bad++; $display("FAIL lat_rsp_count: got %0d want 1", b_rsp_count[15:0]); end
        total++;
        if (b_outstanding[15:0] !== 16'd0) begin bad++; $display("FAIL lat_outstanding: got %0d want 0", b_outstanding[15:0]); end
        total++;
        if (b_nerr !== 0) begin bad++; $display("FAIL lat_no_err: got %0d events want 0", b_nerr); end
    endtask

    task automatic test_orphan();
        b_rsp_valid[1] = 1'b1; b_rsp_tag[11:6] = 6'd9;
        step();
        b_rsp_valid = '0;
        total++;
        if ({b_err_valid, b_err_code, b_err_ch, b_err_tag} !== {1'b1, 2'd1, 2'd1, 6'd9}) begin
            bad++; $display("FAIL orphan_event: got v=%b code=%0d ch=%0d tag=%0d want v=1 code=1 ch=1 tag=9", b_err_valid, b_err_code, b_err_ch, b_err_tag);
        end
        total++;
        if (b_err_sticky !== 6'b001_000) begin bad++; $display("FAIL orphan_sticky: got %b want 001000", b_err_sticky); end
        step();
        total++;
        if (b_err_valid !== 1'b0) begin bad++; $display("FAIL orphan_pulse: got %b want 0", b_err_valid); end
    endtask

    task automatic test_dup();
        do_reset();
        goto(5);
        b_req_valid[0] = 1'b1; b_req_tag[5:0] = 6'd3;
        step();
        b_req_valid = '0;
        goto(8);
        b_req_valid[0] = 1'b1;
        step();
        b_req_valid = '0;
        total++;
        if ({b_err_valid, b_err_code, b_err_ch, b_err_tag} !== {1'b1, 2'd2, 2'd0, 6'd3}) begin
            bad++; $display("FAIL dup_event: got v=%b code=%0d ch=%0d tag=%0d want v=1 code=2 ch=0 tag=3", b_err_valid, b_err_code, b_err_ch, b_err_tag);
        end
        total++;
        if (b_outstanding[15:0] !== 16'd1) begin bad++; $display("FAIL dup_outstanding: got %0d want 1", b_outstanding[15:0]); end
        goto(12);
        b_rsp_valid[0] = 1'b1; b_rsp_tag[5:0] = 6'd3;
        step();
        b_rsp_valid = '0;
        total++;
        if (b_lat_max[31:0] !== 32'd4) begin bad++; $display("FAIL dup_lat_max: got %0d want 4", b_lat_max[31:0]); end
        total++;
        if (b_outstanding[15:0] !== 16'd0) begin bad++; $display("FAIL dup_outstanding_end: got %0d want 0", b_outstanding[15:0]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        b_req_valid[0] = 1'b1; b_req_tag[5:0] = 6'd4;
        step();
        b_req_valid = '0;
        goto(3);
        b_req_valid[0] = 1'b1; b_rsp_valid[0] = 1'b1; b_rsp_tag[5:0] = 6'd4;
        step();
        total++;
        if ({b_outstanding[15:0], b_rsp_count[15:0], b_lat_max[31:0]} !== {16'd1, 16'd1, 32'd3}) begin
            bad++; $display("FAIL b2b_retire_realloc: got out=%0d cnt=%0d lat=%0d want 1 1 3", b_outstanding[15:0], b_rsp_count[15:0], b_lat_max[31:0]);
        end
        total++;
        if (b_err_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_err: got %b want 0", b_err_valid); end
        b_req_tag[5:0] = 6'd6; b_rsp_tag[5:0] = 6'd6;
        step();
        b_req_valid = '0; b_rsp_valid = '0;
        total++;
        if ({b_err_valid, b_err_code, b_err_tag, b_outstanding[15:0], b_rsp_count[15:0]} !== {1'b1, 2'd1, 6'd6, 16'd2, 16'd1}) begin
            bad++; $display("FAIL b2b_idle_orphan: got v=%b code=%0d tag=%0d out=%0d cnt=%0d want 1 1 6 2 1", b_err_valid, b_err_code, b_err_tag, b_outstanding[15:0], b_rsp_count[15:0]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        s_req_valid[0] = 1'b1; s_req_tag[1:0] = 2'd1;
        step();
        s_req_valid = '0;
        goto(40);
        total++;
        if (s_nerr !== 1) begin bad++; $display("FAIL tmo_count: got %0d events want 1", s_nerr); end
        total++;
        if ({s_last_t, s_last_code, s_last_ch, s_last_tag} !== {32'd18, 2'd3, 2'd0, 2'd1}) begin
            bad++; $display("FAIL tmo_event: got t=%0d code=%0d ch=%0d tag=%0d want t=18 code=3 ch=0 tag=1", s_last_t, s_last_code, s_last_ch, s_last_tag);
        end
        s_rsp_valid[0] = 1'b1; s_rsp_tag[1:0] = 2'd1;
        step();
        s_rsp_valid = '0;
        step();
        total++;
        if ({s_rsp_count[15:0], s_outstanding[15:0], s_lat_max[31:0]} !== {16'd1, 16'd0, 32'd40}) begin
            bad++; $display("FAIL tmo_late_rsp: got cnt=%0d out=%0d lat=%0d want 1 0 40", s_rsp_count[15:0], s_outstanding[15:0], s_lat_max[31:0]);
        end
        total++;
        if (s_nerr !== 1 || s_err_sticky[2:0] !== 3'b100) begin
            bad++; $display("FAIL tmo_no_orphan: got events=%0d sticky=%b want 1 100", s_nerr, s_err_sticky[2:0]);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        s_req_valid[1] = 1'b1; s_req_tag[3:2] = 2'd2;
        step();
        s_req_tag[3:2] = 2'd3;
        step();
        s_req_valid = '0;
        goto(18);
        s_rsp_valid[0] = 1'b1; s_rsp_tag[1:0] = 2'd0;
        s_req_valid[1] = 1'b1; s_req_tag[3:2] = 2'd3;
        step();
        idle_inputs();
        total++;
        if ({s_err_valid, s_err_code, s_err_ch, s_err_tag} !== {1'b1, 2'd1, 2'd0, 2'd0}) begin
            bad++; $display("FAIL arb_winner: got v=%b code=%0d ch=%0d tag=%0d want v=1 code=1 ch=0 tag=0", s_err_valid, s_err_code, s_err_ch, s_err_tag);
        end
        total++;
        if (s_err_drop_cnt !== 16'd2) begin bad++; $display("FAIL arb_drop: got %0d want 2", s_err_drop_cnt); end
        total++;
        if (s_err_sticky !== 6'b110_001) begin bad++; $display("FAIL arb_sticky: got %b want 110001", s_err_sticky); end
        total++;
        if (s_nerr !== 1) begin bad++; $display("FAIL arb_single_event: got %0d want 1", s_nerr); end
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        total++;
        if ({s_err_drop_cnt, s_err_sticky, s_outstanding[31:16]} !== {16'd0, 6'd0, 16'd2}) begin
            bad++; $display("FAIL arb_clear: got drop=%0d sticky=%b out1=%0d want 0 0 2", s_err_drop_cnt, s_err_sticky, s_outstanding[31:16]);
        end
        s_rsp_valid[1] = 1'b1; s_rsp_tag[3:2] = 2'd2;
        step();
        s_rsp_valid = '0;
        step();
        total++;
        if (s_nerr !== 1 || s_rsp_count[31:16] !== 16'd1) begin
            bad++; $display("FAIL arb_table_kept: got events=%0d cnt1=%0d want 1 1", s_nerr, s_rsp_count[31:16]);
        end
    endtask

    task automatic test_fill_clear_reset();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            b_req_valid[0] = 1'b1; b_req_tag[5:0] = 6'(i);
            step();
        end
        b_req_valid = '0;
        step();
        total++;
        if ({b_outstanding[15:0], b_hwm[15:0]} !== {16'd64, 16'd64}) begin
            bad++; $display("FAIL fill: got out=%0d hwm=%0d want 64 64", b_outstanding[15:0], b_hwm[15:0]);
        end
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        total++;
        if ({b_outstanding[15:0], b_hwm[15:0]} !== {16'd64, 16'd0}) begin
            bad++; $display("FAIL fill_clear: got out=%0d hwm=%0d want 64 0", b_outstanding[15:0], b_hwm[15:0]);
        end
        step();
        total++;
        if (b_hwm[15:0] !== 16'd64) begin bad++; $display("FAIL fill_hwm_recover: got %0d want 64", b_hwm[15:0]); end
        total++;
        if (b_nerr !== 0) begin bad++; $display("FAIL fill_no_err: got %0d events want 0", b_nerr); end
        for (int i = 0; i < 5; i++) begin
            b_rsp_valid[0] = 1'b1; b_rsp_tag[5:0] = 6'(i);
            step();
        end
        #2;
        b_rst = 1'b1;
        #1;
        total++;
        if ({b_outstanding, b_hwm, b_rsp_count, b_lat_max, b_err_sticky, b_err_valid, b_err_code,
             b_err_ch, b_err_tag, b_err_drop_cnt} !== '0) begin
            bad++; $display("FAIL midburst_reset: got out=%0d cnt=%0d hwm=%0d want all zero", b_outstanding[15:0], b_rsp_count[15:0], b_hwm[15:0]);
        end
        b_rsp_valid = '0;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        b_rsp_valid[0] = 1'b1; b_rsp_tag[5:0] = 6'd7;
        step();
        b_rsp_valid = '0;
        total++;
        if ({b_err_valid, b_err_code, b_err_ch, b_err_tag} !== {1'b1, 2'd1, 2'd0, 6'd7}) begin
            bad++; $display("FAIL post_reset_orphan: got v=%b code=%0d ch=%0d tag=%0d want v=1 code=1 ch=0 tag=7", b_err_valid, b_err_code, b_err_ch, b_err_tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_orphan();
        test_dup();
        test_back_to_back();
        test_timeout();
        test_arbitration();
        test_fill_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
